// File: rtl/qmath_pkg.sv
// Shared definitions for the sequential sign-magnitude fixed-point math units.
package qmath_pkg;

    localparam int unsigned QM_Q = 32;
    localparam int unsigned QM_N = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FINISH,
        ST_DONE
    } qm_state_e;

    // Largest magnitude of an n-bit sign-magnitude word (n-1 ones).
    function automatic logic [63:0] sm_max_mag(input int unsigned n);
        return (64'(1) << (n - 1)) - 64'(1);
    endfunction

endpackage

// File: rtl/qmult_seq.sv
// Sequential shift-add sign-magnitude fixed-point multiplier; resolves one
// multiplier bit per clock, then truncates the Q fraction bits and saturates.
module qmult_seq
    import qmath_pkg::*;
#(
    parameter int unsigned Q = QM_Q,
    parameter int unsigned N = QM_N
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_product_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int unsigned MAG_W = N - 1;
    localparam int unsigned ACC_W = 2 * MAG_W;
    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(sm_max_mag(N));

    qm_state_e        state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] mcand_q, mcand_d;
    logic [MAG_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q;

    logic [MAG_W-1:0] mag_c;
    logic             ovf_c;

    // One shift-add iteration plus result normalisation of the accumulator.
    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        ovf_c    = |acc_q[ACC_W-1:Q+N-1];
        mag_c    = ovf_c ? MAX_MAG : acc_q[Q+N-2:Q];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            cnt_q         <= '0;
            sign_q        <= 1'b0;
            o_product_out <= '0;
            o_complete    <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        mcand_q    <= ACC_W'(i_multiplicand[MAG_W-1:0]);
                        mplier_q   <= i_multiplier[MAG_W-1:0];
                        sign_q     <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                        acc_q      <= '0;
                        cnt_q      <= CNT_W'(MAG_W);
                        o_complete <= 1'b0;
                        o_overflow <= 1'b0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // A zero magnitude never carries a sign.
                    o_product_out <= {sign_q & (|mag_c), mag_c};
                    o_overflow    <= ovf_c;
                    o_complete    <= 1'b1;
                    state_q       <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_seq.sv
// Directed scoreboard bench for qmult_seq: the driver queues hand-computed
// results, an independent monitor checks each rising o_complete.
module tb_qmult_seq;

    localparam int unsigned N = 64;

    typedef struct {
        logic [63:0] prod;
        logic        ovf;
        int unsigned edge_no;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  mcand = '0;
    logic [N-1:0]  mplier = '0;
    logic          start = 1'b0;
    logic [N-1:0]  product;
    logic          complete;
    logic          overflow;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            results = 0;
    int unsigned   cyc = 0;
    logic          prev_c = 1'b0;

    qmult_seq dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .i_start        (start),
        .o_product_out  (product),
        .o_complete     (complete),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every new result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (complete && !prev_c) begin
            results++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h expected=none", product);
            end else begin
                mon_e = sb.pop_front();
                chk("product", product, mon_e.prod);
                chk("overflow", 64'(overflow), 64'(mon_e.ovf));
                chk("latency_edge", 64'(cyc), 64'(mon_e.edge_no));
            end
        end
        prev_c = complete;
    end

    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] p, input logic o);
        exp_t e;
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        e.prod    = p;
        e.ovf     = o;
        e.edge_no = cyc + 1 + N;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        mcand  = ~a;
        mplier = ~b;
        chk("complete_falls", 64'(complete), 64'(0));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!complete && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!complete) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d_cycles expected=complete", n);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] p, input logic o);
        start_op(a, b, p, o);
        wait_done();
    endtask

    initial begin
        int exp_results;
        exp_results = 0;
        repeat (3) @(negedge clk);
        chk("reset_product", product, 64'h0);
        chk("reset_complete", 64'(complete), 64'(0));
        chk("reset_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;

        run_op(64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 64'h0000_0006_0000_0000, 1'b0);
        run_op(64'h8000_0001_8000_0000, 64'h0000_0002_0000_0000, 64'h8000_0003_0000_0000, 1'b0);
        run_op(64'h8000_0002_0000_0000, 64'h8000_0002_0000_0000, 64'h0000_0004_0000_0000, 1'b0);
        run_op(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 1'b0);
        run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b0);
        run_op(64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        run_op(64'h8001_0000_0000_0000, 64'h0001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_op(64'h8000_0001_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0);
        exp_results = 8;

        // Start held for two cycles: the second sample lands in BUSY.
        begin
            exp_t e;
            @(negedge clk);
            mcand  = 64'h0000_0005_0000_0000;
            mplier = 64'h0000_0000_8000_0000;
            start  = 1'b1;
            e.prod    = 64'h0000_0002_8000_0000;
            e.ovf     = 1'b0;
            e.edge_no = cyc + 1 + N;
            sb.push_back(e);
            @(negedge clk);
            @(negedge clk);
            start = 1'b0;
            wait_done();
            repeat (N + 8) @(negedge clk);
            chk("held_start_single_op", 64'(complete), 64'(1));
        end
        exp_results++;

        // Start pulse during BUSY cycle 10 must be ignored.
        start_op(64'h0000_0007_0000_0000, 64'h8000_0003_0000_0000, 64'h8000_0015_0000_0000, 1'b0);
        repeat (9) @(negedge clk);
        mcand  = 64'h0000_0009_0000_0000;
        mplier = 64'h0000_0009_0000_0000;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done();
        repeat (N + 8) @(negedge clk);
        chk("busy_pulse_ignored", product, 64'h8000_0015_0000_0000);
        exp_results++;

        // Reset in BUSY cycle 20: outputs clear without waiting for a clock edge.
        start_op(64'h0000_0003_0000_0000, 64'h0000_0003_0000_0000, 64'h0000_0009_0000_0000, 1'b0);
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_product", product, 64'h0);
        chk("async_rst_complete", 64'(complete), 64'(0));
        chk("async_rst_overflow", 64'(overflow), 64'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'h0000_0003_0000_0000, 64'h0000_0003_0000_0000, 64'h0000_0009_0000_0000, 1'b0);
        exp_results++;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("result_count", 64'(results), 64'(exp_results));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
